pe_node: RTL and testbench
==========================

Name: pe_node

Overview:
- One mesh processing-element tile: a 5-port Hermes-style wormhole router (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4) with credit-based flow control and XY routing.
- A local ejection sink stores every flit delivered to LOCAL into an on-tile memory.
- Tiles are tiled NOC_DIM_X x NOC_DIM_Y by the top level.
- Mesh signals are carried in the interface_pe bundle (modport PE); border ports are tied to 0 by the top level.

Parameters:
- MEMORY_BUS_WIDTH, 32, memory word width.
- FLIT_WIDTH, 32, flit width.
- ROUTER_ADDR, 0, tile address: x = ROUTER_ADDR[15:8], y = ROUTER_ADDR[7:0].
- MEMORY_SIZE, 1024, sink memory depth in words.
- BUFFER_DEPTH, 4, input FIFO depth per port (power of 2).

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: synchronous, active-high.
- data_i in 5xFLIT_WIDTH: flit in, per port.
- rx in 5: flit valid in, per port.
- credit_o out 5: input FIFO not full, per port.
- clock_rx in 5: unused; single clock domain.
- data_o out 5xFLIT_WIDTH: flit out, per port.
- tx out 5: flit valid out, per port.
- credit_i in 5: downstream can accept; LOCAL entry ignored.
- clock_tx out 5: each equals clock.
- mem_raddr_i in $clog2(MEMORY_SIZE): sink memory read address.
- mem_rdata_o out MEMORY_BUS_WIDTH: read data, 1-cycle latency.
- mem_wptr_o out $clog2(MEMORY_SIZE): next sink write address.
- pkt_count_o out 16: packets fully ejected.

Behaviour:
- Reset (sync, active-high):
  - All FIFOs emptied; all routing and arbitration state cleared.
  - tx=0, data_o=0, credit_o=0 while reset is high; credit_o=1 from the first cycle after reset.
  - mem_wptr_o=0, pkt_count_o=0, mem_rdata_o=0. Memory contents are not reset.
  - Reset mid-packet drops all in-flight flits.
- Transfer rule: a flit moves on a rising edge when rx=1 and credit_o=1 (input side), or tx=1 and credit_i=1 (output side).
  - tx never asserts toward credit_i=0, so grounded borders never receive.
  - Simultaneous push and pop on a full FIFO is allowed; credit_o stays 1 only if not full after the edge.
- Packet format:
  - Flit 0 is the header: target x = [15:8], target y = [7:0].
  - Flit 1 is the size N: payload flit count.
  - Flits 2..N+1 are payload; total N+2 flits. N=0 is legal (2 flits).
- XY routing, applied per input header:
  - tx_x > x -> EAST; tx_x < x -> WEST.
  - Otherwise tx_y > y -> NORTH; tx_y < y -> SOUTH.
  - Otherwise LOCAL.
- Arbitration:
  - One routing decision per cycle.
  - Round-robin over inputs with a header at FIFO head, starting after the last granted input.
  - Requests to a busy output wait.
- Connection:
  - Granted input->output held until N+2 flits have left on that output, then released.
  - Flits forwarded one per cycle while the FIFO is non-empty and credit_i=1.
  - U-turns (output == input port) are not generated by XY routing; no special handling required.
- Latency: header accepted at edge k -> routed at edge k+1 -> tx=1 with the header after edge k+2. Streaming throughput is 1 flit/cycle.
- LOCAL output:
  - data_o[4]/tx[4] mirror ejected flits and are always consumed.
  - Each ejected flit (header and size included) is written to mem[mem_wptr_o], zero-extended or truncated to MEMORY_BUS_WIDTH.
  - mem_wptr_o increments mod MEMORY_SIZE, wrapping with overwrite.
  - pkt_count_o increments on each tail flit and wraps at 2^16.
- clock_tx[p] = clock for all p.

Decomposition:
- Package pe_pkg holds:
  - The port enum e_port (EAST..LOCAL).
  - NPORT=5.
  - Header field slice constants.
  - Function xy_route(local_addr, target_addr) returning e_port.
- Sub-module pe_input_buffer (one per port): FIFO with credit_o = !full, plus the header/size/flit counter that tracks packet state.
- Crossbar, round-robin arbiter and ejection sink stay in pe_node.

Test Plan:
- Reset: hold reset 2 cycles -> tx=0, data_o=0, credit_o=0 during reset; credit_o=5'b11111 after; mem_wptr_o=0; pkt_count_o=0.
- Local loopback at ROUTER_ADDR=16'h0101:
  - Stimulus: inject on LOCAL header 0x0101, size 2, payload 0xA, 0xB.
  - Required: mem[0..3] = 0x0101, 2, 0xA, 0xB; pkt_count_o=1; mem_wptr_o=4.
- Routing at ROUTER_ADDR=16'h0101:
  - Headers 0x0201 / 0x0001 / 0x0102 / 0x0100 injected on LOCAL exit EAST / WEST / NORTH / SOUTH respectively.
  - Header appears on data_o after edge k+2.
- Backpressure:
  - Route a 6-flit packet EAST with credit_i[EAST]=0 -> tx[EAST] stays 0 and the LOCAL FIFO fills (credit_o[LOCAL]=0 after 4 flits).
  - Raise credit_i -> all 6 flits delivered in order.
- Contention: WEST and SOUTH inputs both send to LOCAL in the same cycle -> packets are not interleaved; the second starts after the first tail; repeating the test alternates the winner.
- Wrap: MEMORY_SIZE=8; eject 3 packets of 3 flits -> mem_wptr_o=1 and mem[0] holds flit 9.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, header field layout and XY routing for the mesh tile
package pe_pkg;

    localparam int NPORT = 5;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    // Position of the flit at the head of an input FIFO within its packet
    typedef enum logic [1:0] {
        PKT_HEADER,
        PKT_SIZE,
        PKT_PAYLOAD
    } e_pkt_state;

    // Address fields inside a header flit (and inside ROUTER_ADDR)
    localparam int X_HI = 15;
    localparam int X_LO = 8;
    localparam int Y_HI = 7;
    localparam int Y_LO = 0;

    // Dimension-ordered routing: resolve X first, then Y, then eject
    function automatic e_port xy_route(input logic [15:0] local_addr,
                                       input logic [15:0] target_addr);
        logic [7:0] lx;
        logic [7:0] ly;
        logic [7:0] tx;
        logic [7:0] ty;
        e_port      dir;
        lx = local_addr[X_HI:X_LO];
        ly = local_addr[Y_HI:Y_LO];
        tx = target_addr[X_HI:X_LO];
        ty = target_addr[Y_HI:Y_LO];
        if (tx > lx)      dir = EAST;
        else if (tx < lx) dir = WEST;
        else if (ty > ly) dir = NORTH;
        else if (ty < ly) dir = SOUTH;
        else              dir = LOCAL;
        return dir;
    endfunction

endpackage

// File: rtl/pe_input_buffer.sv
// rtl/pe_input_buffer.sv - per-port input FIFO with credit output and packet framing tracker
module pe_input_buffer
    import pe_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FLIT_WIDTH-1:0] data_i,
    input  logic                  rx,
    output logic                  credit_o,
    input  logic                  pop,
    output logic [FLIT_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  head_is_header,
    output logic                  head_is_tail
);

    localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    logic [FLIT_WIDTH-1:0] store [BUFFER_DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  push;
    logic                  do_pop;

    e_pkt_state            state;
    e_pkt_state            state_n;
    logic [FLIT_WIDTH-1:0] remaining;
    logic [FLIT_WIDTH-1:0] remaining_n;

    // Credit is withheld during reset so upstream never pushes into a clearing FIFO
    assign full     = (count == (AW+1)'(BUFFER_DEPTH));
    assign empty    = (count == '0);
    assign credit_o = ~reset & ~full;
    assign push     = rx & credit_o;
    assign do_pop   = pop & ~empty;
    assign head     = store[rptr];

    // FIFO storage; contents need no reset, validity lives in count
    always_ff @(posedge clock) begin
        if (push) store[wptr] <= data_i;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet framing state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PKT_HEADER;
            remaining <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
        end
    end

    // Framing next-state: the size flit loads the payload countdown
    always_comb begin
        state_n        = state;
        remaining_n    = remaining;
        head_is_header = ~empty && (state == PKT_HEADER);
        head_is_tail   = ((state == PKT_SIZE) && (head == '0)) ||
                         ((state == PKT_PAYLOAD) && (remaining == FLIT_WIDTH'(1)));
        if (do_pop) begin
            case (state)
                PKT_HEADER: state_n = PKT_SIZE;
                PKT_SIZE: begin
                    if (head == '0) begin
                        state_n = PKT_HEADER;
                    end else begin
                        state_n     = PKT_PAYLOAD;
                        remaining_n = head;
                    end
                end
                PKT_PAYLOAD: begin
                    remaining_n = remaining - 1'b1;
                    if (remaining == FLIT_WIDTH'(1)) state_n = PKT_HEADER;
                end
                default: state_n = PKT_HEADER;
            endcase
        end
    end

endmodule

// File: rtl/pe_node.sv
// rtl/pe_node.sv - 5-port wormhole XY router tile with local ejection memory
module pe_node
    import pe_pkg::*;
#(
    parameter int          MEMORY_BUS_WIDTH = 32,
    parameter int          FLIT_WIDTH       = 32,
    parameter logic [15:0] ROUTER_ADDR      = 16'h0000,
    parameter int          MEMORY_SIZE      = 1024,
    parameter int          BUFFER_DEPTH     = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NPORT-1:0][FLIT_WIDTH-1:0]      data_i,
    input  logic [NPORT-1:0]                      rx,
    output logic [NPORT-1:0]                      credit_o,
    input  logic [NPORT-1:0]                      clock_rx,
    output logic [NPORT-1:0][FLIT_WIDTH-1:0]      data_o,
    output logic [NPORT-1:0]                      tx,
    input  logic [NPORT-1:0]                      credit_i,
    output logic [NPORT-1:0]                      clock_tx,
    input  logic [$clog2(MEMORY_SIZE)-1:0]        mem_raddr_i,
    output logic [MEMORY_BUS_WIDTH-1:0]           mem_rdata_o,
    output logic [$clog2(MEMORY_SIZE)-1:0]        mem_wptr_o,
    output logic [15:0]                           pkt_count_o
);

    localparam int MW = $clog2(MEMORY_SIZE);

    logic [NPORT-1:0][FLIT_WIDTH-1:0] head;
    logic [NPORT-1:0]                 empty;
    logic [NPORT-1:0]                 is_hdr;
    logic [NPORT-1:0]                 is_tail;
    logic [NPORT-1:0]                 pop;
    e_port                            want [NPORT];

    logic [NPORT-1:0]                 conn_valid;
    e_port                            conn_src [NPORT];
    logic [NPORT-1:0]                 in_busy;
    logic [NPORT-1:0]                 req;
    logic [NPORT-1:0]                 pop_out;
    logic [NPORT-1:0]                 out_credit;
    logic [NPORT-1:0]                 out_valid;
    logic [NPORT-1:0][FLIT_WIDTH-1:0] out_data;
    logic [NPORT-1:0]                 out_tail;

    e_port                            last_grant;
    e_port                            grant_idx;
    logic                             grant_valid;
    logic [2:0]                       rr_idx;

    logic [MEMORY_BUS_WIDTH-1:0]      mem [MEMORY_SIZE];
    logic [MEMORY_BUS_WIDTH-1:0]      sink_wdata;
    logic [MW-1:0]                    mem_wptr;
    logic [15:0]                      pkt_count;
    logic                             unused_inputs;

    assign unused_inputs = ^{clock_rx, credit_i[LOCAL]};
    assign clock_tx      = {NPORT{clock}};
    // The local sink is always ready, so its credit is forced high
    assign out_credit    = {1'b1, credit_i[NPORT-2:0]};

    for (genvar p = 0; p < NPORT; p++) begin : g_in
        pe_input_buffer #(
            .FLIT_WIDTH   (FLIT_WIDTH),
            .BUFFER_DEPTH (BUFFER_DEPTH)
        ) u_buf (
            .clock          (clock),
            .reset          (reset),
            .data_i         (data_i[p]),
            .rx             (rx[p]),
            .credit_o       (credit_o[p]),
            .pop            (pop[p]),
            .head           (head[p]),
            .empty          (empty[p]),
            .head_is_header (is_hdr[p]),
            .head_is_tail   (is_tail[p])
        );
    end

    // Route every input header and work out which inputs may be granted
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            want[i]    = xy_route(ROUTER_ADDR, head[i][15:0]);
            in_busy[i] = 1'b0;
            for (int o = 0; o < NPORT; o++) begin
                if (conn_valid[o] && (int'(conn_src[o]) == i)) in_busy[i] = 1'b1;
            end
            req[i] = is_hdr[i] && !in_busy[i] && !conn_valid[want[i]];
        end
    end

    // Round-robin: first requester after the last granted input wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        rr_idx      = '0;
        for (int k = 1; k <= NPORT; k++) begin
            rr_idx = 3'((int'(last_grant) + k) % NPORT);
            if (!grant_valid && req[rr_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = e_port'(rr_idx);
            end
        end
    end

    // Crossbar: an input is popped only while its output has credit, so tx never faces credit 0
    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORT; o++) begin
            pop_out[o] = conn_valid[o] && !empty[conn_src[o]] && out_credit[o];
            if (pop_out[o]) pop[conn_src[o]] = 1'b1;
        end
    end

    // Connection table, output stage and arbitration pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            conn_valid <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            out_tail   <= '0;
            last_grant <= EAST;
            for (int o = 0; o < NPORT; o++) conn_src[o] <= EAST;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (pop_out[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= head[conn_src[o]];
                    out_tail[o]  <= is_tail[conn_src[o]];
                    if (is_tail[conn_src[o]]) conn_valid[o] <= 1'b0;
                end else if (out_valid[o] && out_credit[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            if (grant_valid) begin
                conn_valid[want[grant_idx]] <= 1'b1;
                conn_src[want[grant_idx]]   <= grant_idx;
                last_grant                  <= grant_idx;
            end
        end
    end

    // Outputs are forced quiet while reset is held
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            tx[o]     = ~reset & out_valid[o] & out_credit[o];
            data_o[o] = reset ? '0 : out_data[o];
        end
    end

    assign sink_wdata = MEMORY_BUS_WIDTH'(out_data[LOCAL]);

    // Ejection memory write port; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && out_valid[LOCAL]) mem[mem_wptr] <= sink_wdata;
    end

    // Ejection write pointer and completed-packet counter
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wptr  <= '0;
            pkt_count <= '0;
        end else if (out_valid[LOCAL]) begin
            mem_wptr <= (mem_wptr == MW'(MEMORY_SIZE - 1)) ? '0 : mem_wptr + 1'b1;
            if (out_tail[LOCAL]) pkt_count <= pkt_count + 1'b1;
        end
    end

    // Registered read port
    always_ff @(posedge clock) begin
        if (reset) mem_rdata_o <= '0;
        else       mem_rdata_o <= mem[mem_raddr_i];
    end

    assign mem_wptr_o  = mem_wptr;
    assign pkt_count_o = pkt_count;

endmodule

// File: tb/tb_pe_node.sv
// tb/tb_pe_node.sv - self-checking bench for pe_node with a packet scoreboard
module tb_pe_node;

    localparam int FW  = 32;
    localparam int MSZ = 8;
    localparam int AW  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [4:0][FW-1:0] data_i;
    logic [4:0][FW-1:0] data_o;
    logic [4:0]        rx;
    logic [4:0]        credit_o;
    logic [4:0]        clock_rx;
    logic [4:0]        tx;
    logic [4:0]        credit_i;
    logic [4:0]        clock_tx;
    logic [AW-1:0]     mem_raddr_i;
    logic [31:0]       mem_rdata_o;
    logic [AW-1:0]     mem_wptr_o;
    logic [15:0]       pkt_count_o;

    typedef struct {
        int          port;
        int          len;
        logic [31:0] f [16];
    } pkt_t;

    pkt_t        pending [$];
    logic [31:0] local_log [$];
    int          tests = 0;
    int          fails = 0;
    int          accepted [5];
    int          rl [5];
    int          rt [5];
    logic [31:0] rbuf [5][16];
    int          hit;
    bit          same;
    logic [31:0] rd_val;

    always #5 clock = ~clock;
    assign clock_rx = {5{clock}};

    pe_node #(
        .MEMORY_BUS_WIDTH (32),
        .FLIT_WIDTH       (FW),
        .ROUTER_ADDR      (16'h0101),
        .MEMORY_SIZE      (MSZ),
        .BUFFER_DEPTH     (4)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .data_i      (data_i),
        .rx          (rx),
        .credit_o    (credit_o),
        .clock_rx    (clock_rx),
        .data_o      (data_o),
        .tx          (tx),
        .credit_i    (credit_i),
        .clock_tx    (clock_tx),
        .mem_raddr_i (mem_raddr_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_wptr_o  (mem_wptr_o),
        .pkt_count_o (pkt_count_o)
    );

    // Exit port of a header at tile (1,1): fix X first, then Y, else eject
    function automatic int model_route(input logic [31:0] hdr);
        int tgt_x;
        int tgt_y;
        tgt_x = int'(hdr[15:8]);
        tgt_y = int'(hdr[7:0]);
        if (tgt_x > 1) return 0;
        if (tgt_x < 1) return 1;
        if (tgt_y > 1) return 2;
        if (tgt_y < 1) return 3;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base);
        pkt_t pk;
        pk.port = model_route(hdr);
        pk.len  = n + 2;
        for (int j = 0; j < 16; j++) pk.f[j] = '0;
        pk.f[0] = hdr;
        pk.f[1] = n;
        for (int j = 0; j < n; j++) pk.f[2+j] = base + j;
        pending.push_back(pk);
    endtask

    task automatic send_pkt(input int p, input logic [31:0] hdr, input int n, input logic [31:0] base);
        logic [31:0] fl;
        logic        ok;
        int          guard;
        expect_pkt(hdr, n, base);
        @(posedge clock); #1;
        for (int j = 0; j < n + 2; j++) begin
            fl = (j == 0) ? hdr : (j == 1) ? n : base + (j - 2);
            data_i[p] = fl;
            rx[p]     = 1'b1;
            guard     = 0;
            ok        = 1'b0;
            while (!ok && guard < 200) begin
                @(negedge clock);
                ok = credit_o[p];
                @(posedge clock); #1;
                guard++;
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL send_timeout port %0d flit %0d: got no credit, required credit within 200 cycles", p, j);
            end else begin
                accepted[p]++;
            end
        end
        rx[p] = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        mem_raddr_i = AW'(a);
        @(posedge clock); #1;
        d = mem_rdata_o;
    endtask

    // Header accepted at edge k must be absent after k+1 and present after k+2
    task automatic route_check(input logic [31:0] hdr, input int o, input string nm);
        chk({nm, "_model"}, model_route(hdr), o);
        expect_pkt(hdr, 0, 0);
        @(posedge clock); #1;
        data_i[4] = hdr;
        rx[4]     = 1'b1;
        @(posedge clock); #1;
        data_i[4] = 32'd0;
        @(posedge clock); #1;
        rx[4] = 1'b0;
        @(negedge clock);
        chk({nm, "_tx_k1"}, tx[o], 1'b0);
        @(negedge clock);
        chk({nm, "_tx_k2"}, tx[o], 1'b1);
        chk({nm, "_hdr_k2"}, data_o[o], hdr);
        wait_idle(8);
    endtask

    // Scoreboard: frame each output stream into packets and match whole packets
    always @(negedge clock) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) rl[p] = 0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (p < 4 && !credit_i[p]) begin
                    tests++;
                    if (tx[p]) begin
                        fails++;
                        $display("FAIL tx_without_credit port %0d: got tx 1, required 0", p);
                    end
                end
                if (tx[p]) begin
                    rbuf[p][rl[p]] = data_o[p];
                    rl[p]++;
                    if (rl[p] == 2) rt[p] = int'(data_o[p]) + 2;
                    if (rl[p] >= 2 && rl[p] == rt[p]) begin
                        hit = -1;
                        foreach (pending[k]) begin
                            if (hit < 0 && pending[k].port == p && pending[k].len == rl[p]) begin
                                same = 1'b1;
                                for (int j = 0; j < rl[p]; j++)
                                    if (pending[k].f[j] !== rbuf[p][j]) same = 1'b0;
                                if (same) hit = k;
                            end
                        end
                        tests++;
                        if (hit < 0) begin
                            fails++;
                            $display("FAIL pkt_port%0d: got hdr %h size %0d first %h, required a matching sent packet",
                                     p, rbuf[p][0], rbuf[p][1], rbuf[p][2]);
                        end else begin
                            if (p == 4) local_log.push_back(rbuf[p][2]);
                            pending.delete(hit);
                        end
                        rl[p] = 0;
                    end else if (rl[p] >= 16) begin
                        tests++;
                        fails++;
                        $display("FAIL pkt_overlong port %0d: got 16 flits, required packet end", p);
                        rl[p] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish by 200us");
        $fatal(1);
    end

    initial begin
        rx          = '0;
        data_i      = '0;
        credit_i    = '1;
        mem_raddr_i = '0;
        for (int p = 0; p < 5; p++) accepted[p] = 0;

        // Reset held for two edges
        @(negedge clock);
        chk("rst_tx", tx, 5'b0);
        chk("rst_data", data_o[0] | data_o[1] | data_o[2] | data_o[3] | data_o[4], 32'd0);
        chk("rst_credit", credit_o, 5'b0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_credit", credit_o, 5'b11111);
        chk("post_rst_wptr", mem_wptr_o, 3'd0);
        chk("post_rst_pkts", pkt_count_o, 16'd0);

        // Local loopback
        send_pkt(4, 32'h0101, 2, 32'hA);
        wait_idle(15);
        chk("loop_pkts", pkt_count_o, 16'd1);
        chk("loop_wptr", mem_wptr_o, 3'd4);
        rd(0, rd_val); chk("loop_mem0", rd_val, 32'h0101);
        rd(1, rd_val); chk("loop_mem1", rd_val, 32'd2);
        rd(2, rd_val); chk("loop_mem2", rd_val, 32'hA);
        rd(3, rd_val); chk("loop_mem3", rd_val, 32'hB);

        // Routing and header latency
        route_check(32'h0201, 0, "route_east");
        route_check(32'h0001, 1, "route_west");
        route_check(32'h0102, 2, "route_north");
        route_check(32'h0100, 3, "route_south");

        // Backpressure on EAST
        credit_i[0] = 1'b0;
        accepted[4] = 0;
        fork
            send_pkt(4, 32'h0201, 4, 32'h61);
            begin
                repeat (12) @(posedge clock);
                @(negedge clock);
                chk("bp_accepted", accepted[4], 4);
                chk("bp_credit_local", credit_o[4], 1'b0);
                chk("bp_tx_east", tx[0], 1'b0);
                @(posedge clock); #1;
                credit_i[0] = 1'b1;
            end
        join
        wait_idle(15);
        chk("bp_delivered", pending.size(), 0);

        // Contention: previous grant was LOCAL, so WEST is found first
        local_log.delete();
        fork
            send_pkt(1, 32'h0101, 2, 32'h100);
            send_pkt(3, 32'h0101, 3, 32'h300);
        join
        wait_idle(20);
        chk("cont1_count", local_log.size(), 2);
        chk("cont1_first", local_log[0], 32'h100);
        chk("cont1_second", local_log[1], 32'h300);

        // After a grant to WEST the search starts at NORTH, so SOUTH wins
        send_pkt(1, 32'h0201, 0, 32'h0);
        wait_idle(10);
        local_log.delete();
        fork
            send_pkt(1, 32'h0101, 2, 32'h100);
            send_pkt(3, 32'h0101, 3, 32'h300);
        join
        wait_idle(20);
        chk("cont2_count", local_log.size(), 2);
        chk("cont2_first", local_log[0], 32'h300);
        chk("cont2_second", local_log[1], 32'h100);

        // Sink wrap with an 8-word memory
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send_pkt(4, 32'h0101, 1, 32'hC1 + i);
        wait_idle(15);
        chk("wrap_wptr", mem_wptr_o, 3'd1);
        chk("wrap_pkts", pkt_count_o, 16'd3);
        rd(0, rd_val); chk("wrap_mem0", rd_val, 32'hC3);
        rd(7, rd_val); chk("wrap_mem7", rd_val, 32'd1);
        rd(2, rd_val); chk("wrap_mem2", rd_val, 32'hC1);

        chk("all_delivered", pending.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
